// File: rtl/cntr_run_ctrl.sv
// Run/stop/single-step sequencer and freeze-snapshot logic for the LED counter's clock-enable.
// Optional breakpoint halt is compiled in when CNTR_RUN_CTRL_BREAK_EN is defined.
module cntr_run_ctrl #(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cnt_en,
  input  logic [CNT_W-1:0]  cnt_q,
  output logic              cap_valid,
  output logic [CNT_W-1:0]  cap_data,
  input  logic              cap_ready,
  output logic              done,
  output logic              busy
`ifdef CNTR_RUN_CTRL_BREAK_EN
  ,
  input  logic              bp_en,
  input  logic [CNT_W-1:0]  bp_val,
  output logic              bp_hit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_SETTLE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [1:0] OP_STOP    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_CAPTURE = 2'b11;

  state_t              state_q, state_d;
  logic                cnt_en_q, cnt_en_d;
  logic                done_q, done_d;
  logic                cap_valid_q, cap_valid_d;
  logic [CNT_W-1:0]    cap_data_q, cap_data_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                accept;
  logic                bp_trip;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;

`ifdef CNTR_RUN_CTRL_BREAK_EN
  logic                bp_hit_q;
  logic [CNT_W-1:0]    bp_prev;

  // The halt decision is made one count early so the counter's final increment lands on bp_val.
  assign bp_prev = bp_val - CNT_W'(1);
  assign bp_trip = cnt_en_q && bp_en && (cnt_q == bp_prev) &&
                   ((state_q == S_RUN) || (state_q == S_STEP));

  always_ff @(posedge clk) begin
    if (!reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_trip;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  assign bp_trip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_en_d    = cnt_en_q;
    done_d      = 1'b0;
    cap_valid_d = cap_valid_q;
    cap_data_d  = cap_data_q;
    step_d      = step_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_RUN: begin
              state_d  = S_RUN;
              cnt_en_d = 1'b1;
            end
            OP_STEP: begin
              if (cmd_arg != '0) begin
                state_d  = S_STEP;
                cnt_en_d = 1'b1;
                step_d   = cmd_arg;
              end else begin
                done_d = 1'b1;
              end
            end
            OP_CAPTURE: state_d = S_SETTLE;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (accept && (cmd_op == OP_STOP)) begin
          cnt_en_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (accept && (cmd_op == OP_CAPTURE)) begin
          cnt_en_d = 1'b0;
          state_d  = S_SETTLE;
        end
        // A breakpoint coinciding with CAPTURE still honours the capture.
        if (bp_trip) begin
          cnt_en_d = 1'b0;
          done_d   = 1'b1;
          if (state_d == S_RUN) state_d = S_IDLE;
        end
      end

      S_STEP: begin
        if (cnt_en_q && (step_q != '0)) step_d = step_q - STEP_W'(1);
        if ((step_q == STEP_W'(1)) || bp_trip) begin
          cnt_en_d = 1'b0;
          done_d   = 1'b1;
          step_d   = '0;
          state_d  = S_IDLE;
        end
      end

      S_SETTLE: begin
        cap_data_d  = cnt_q;
        cap_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (cap_ready) begin
          cap_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_en_d    = 1'b0;
        cap_valid_d = 1'b0;
        step_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_en_q    <= 1'b0;
      done_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_en_q    <= cnt_en_d;
      done_q      <= done_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      step_q      <= step_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign done      = done_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cntr_run_ctrl.sv
// Bench for cntr_run_ctrl: models the LED counter, drives directed and random commands,
// and checks outputs against per-command expectations computed from counts and distances.
module tb_cntr_run_ctrl;
  localparam int CNT_W  = 8;
  localparam int STEP_W = 16;
  localparam logic [1:0] OP_STOP = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_CAP = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [STEP_W-1:0] cmd_arg = '0;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cap_valid;
  logic [CNT_W-1:0]  cap_data;
  logic              cap_ready = 1'b0;
  logic              done;
  logic              busy;
`ifdef CNTR_RUN_CTRL_BREAK_EN
  logic              bp_en = 1'b0;
  logic [CNT_W-1:0]  bp_val = '0;
  logic              bp_hit;
`endif

  logic              load_req = 1'b0;
  logic [CNT_W-1:0]  load_val = '0;
  logic [CNT_W-1:0]  m_cnt;
  int                n_chk = 0;
  int                n_err = 0;

  cntr_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cnt_en(cnt_en), .cnt_q(cnt),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .done(done), .busy(busy)
`ifdef CNTR_RUN_CTRL_BREAK_EN
    , .bp_en(bp_en), .bp_val(bp_val), .bp_hit(bp_hit)
`endif
  );

  always #5 clk = ~clk;

  // The LED counter being controlled.
  always @(posedge clk) begin
    if (load_req) cnt <= load_val;
    else if (cnt_en) cnt <= cnt + 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bp(input string tag, input logic exp);
`ifdef CNTR_RUN_CTRL_BREAK_EN
    chk(tag, bp_hit, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enabled edges until a breakpoint halts the counter, counted from `start`.
  function automatic int bp_dist(input logic [CNT_W-1:0] start);
    logic [CNT_W-1:0] t;
    t = start;
`ifdef CNTR_RUN_CTRL_BREAK_EN
    t = bp_val - start - 8'd1;
    if (bp_en) return int'(t) + 1;
`endif
    return (1 << 30) + int'(t);
  endfunction

  task automatic load_cnt(input logic [CNT_W-1:0] v);
    load_req = 1'b1;
    load_val = v;
    tick();
    load_req = 1'b0;
    m_cnt = v;
  endtask

  task automatic issue(input logic [1:0] op, input int arg);
    cmd_op    = op;
    cmd_arg   = STEP_W'(arg);
    cmd_valid = 1'b1;
    chk("issue_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_step(input int n);
    int d, m;
    d = bp_dist(m_cnt);
    m = (n < d) ? n : d;
    issue(OP_STEP, n);
    for (int i = 0; i < m; i++) begin
      chk("step_en", cnt_en, 1'b1);
      chk("step_busy", busy, 1'b1);
      chk("step_ready", cmd_ready, 1'b0);
      chk("step_done", done, 1'b0);
      tick();
    end
    m_cnt = m_cnt + 8'(m);
    chk("step_end_en", cnt_en, 1'b0);
    chk("step_end_done", done, 1'b1);
    chk("step_end_busy", busy, 1'b0);
    chk("step_end_cnt", cnt, m_cnt);
    chk_bp("step_bp_hit", d <= n);
    tick();
    chk("step_done_clr", done, 1'b0);
    chk("step_cnt_frozen", cnt, m_cnt);
    chk_bp("step_bp_clr", 1'b0);
  endtask

  task automatic do_run(input int dur);
    int d, m;
    d = bp_dist(m_cnt);
    issue(OP_RUN, 0);
    for (int i = 0; i < dur - 1; i++) begin
      chk("run_en", cnt_en, i < d);
      chk("run_done", done, i == d);
      chk("run_busy", busy, i < d);
      chk("run_ready", cmd_ready, 1'b1);
      chk_bp("run_bp", i == d);
      tick();
    end
    issue(OP_STOP, 0);
    m = (dur < d) ? dur : d;
    m_cnt = m_cnt + 8'(m);
    chk("stop_en", cnt_en, 1'b0);
    chk("stop_done", done, d >= dur);
    chk("stop_busy", busy, 1'b0);
    chk("stop_cnt", cnt, m_cnt);
    chk_bp("stop_bp", d == dur);
    tick();
    chk("stop_done_clr", done, 1'b0);
    chk("stop_cnt_frozen", cnt, m_cnt);
  endtask

  task automatic do_capture(input bit run_first, input int dur, input int hold);
    if (run_first) begin
      issue(OP_RUN, 0);
      for (int i = 0; i < dur - 1; i++) begin
        chk("caprun_en", cnt_en, 1'b1);
        chk("caprun_ready", cmd_ready, 1'b1);
        tick();
      end
      m_cnt = m_cnt + 8'(dur);
    end
    issue(OP_CAP, 0);
    chk("settle_en", cnt_en, 1'b0);
    chk("settle_valid", cap_valid, 1'b0);
    chk("settle_busy", busy, 1'b1);
    chk("settle_ready", cmd_ready, 1'b0);
    chk("settle_done", done, 1'b0);
    tick();
    for (int h = 0; h <= hold; h++) begin
      chk("hold_valid", cap_valid, 1'b1);
      chk("hold_data", cap_data, m_cnt);
      chk("hold_cnt", cnt, m_cnt);
      chk("hold_en", cnt_en, 1'b0);
      chk("hold_ready", cmd_ready, 1'b0);
      if (h == hold) cap_ready = 1'b1;
      tick();
    end
    cap_ready = 1'b0;
    chk("cap_done_valid", cap_valid, 1'b0);
    chk("cap_done_busy", busy, 1'b0);
    chk("cap_done_ready", cmd_ready, 1'b1);
  endtask

  task automatic do_stop_idle();
    issue(OP_STOP, 0);
    chk("idle_stop_busy", busy, 1'b0);
    chk("idle_stop_en", cnt_en, 1'b0);
    chk("idle_stop_done", done, 1'b0);
    chk("idle_stop_cnt", cnt, m_cnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"}, cnt_en, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cap_valid"}, cap_valid, 1'b0);
    chk({tag, "_cap_data"}, cap_data, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    load_req = 1'b1;
    load_val = 8'h00;
    repeat (3) tick();
    load_req = 1'b0;
    m_cnt    = 8'h00;
    chk_reset_outputs("rst");
    chk("rst_ready", cmd_ready, 1'b1);
    chk_bp("rst_bp", 1'b0);
    reset = 1'b1;
    tick();

    do_step(5);
    do_run(20);
    do_capture(1'b1, 15, 10);
    do_step(0);
    load_cnt(8'hFE);
    do_step(300);
    chk("wrap_0x2A", cnt, 8'h2A);
    do_stop_idle();
    do_capture(1'b0, 0, 3);

    // Reset in the middle of a long STEP.
    issue(OP_STEP, 1000);
    repeat (10) tick();
    reset = 1'b0;
    tick();
    m_cnt = m_cnt + 8'd11;
    chk_reset_outputs("rst_step");
    chk("rst_step_cnt", cnt, m_cnt);
    reset = 1'b1;
    tick();
    chk("rst_step_frozen", cnt, m_cnt);
    do_run(5);

    // Reset while a snapshot is being held.
    load_cnt(8'hA5);
    issue(OP_CAP, 0);
    tick();
    chk("pre_rst_hold_data", cap_data, 8'hA5);
    tick();
    reset = 1'b0;
    tick();
    chk_reset_outputs("rst_hold");
    reset = 1'b1;
    do_run(6);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_stop_idle();
        1: do_run(int'($urandom_range(2, 30)));
        2: do_step(int'($urandom_range(0, 40)));
        default: do_capture(1'($urandom_range(0, 1)), int'($urandom_range(2, 20)),
                            int'($urandom_range(0, 5)));
      endcase
    end

`ifdef CNTR_RUN_CTRL_BREAK_EN
    bp_en  = 1'b1;
    bp_val = 8'h40;
    load_cnt(8'h00);
    do_run(100);
    chk("bp_run_freeze", cnt, 8'h40);
    load_cnt(8'h3C);
    do_step(10);
    chk("bp_step_freeze", cnt, 8'h40);
    for (int it = 0; it < 8; it++) begin
      bp_val = 8'($urandom_range(0, 255));
      load_cnt(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) do_run(int'($urandom_range(2, 60)));
      else do_step(int'($urandom_range(1, 60)));
    end
    bp_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
